// File: rtl/sram_1rwnr_param_model.sv
// rtl/sram_1rwnr_param_model.sv - parametrised 1RW + N-read synchronous SRAM with init sequencer
module sram_1rwnr_param_model #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int DEPTH        = 512,
    parameter int WMASK_WIDTH  = 4,
    parameter int NUM_RPORTS   = 1,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic                             busy,
    input  logic                             csb0,
    input  logic                             web0,
    input  logic [WMASK_WIDTH-1:0]           wmask0,
    input  logic [ADDR_WIDTH-1:0]            addr0,
    input  logic [DATA_WIDTH-1:0]            din0,
    output logic [DATA_WIDTH-1:0]            dout0,
    output logic                             dout0_valid,
    input  logic [NUM_RPORTS-1:0]            csb1,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] addr1,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] dout1,
    output logic [NUM_RPORTS-1:0]            dout1_valid,
    output logic                             access_err,
    output logic                             collision
);
    localparam int NP = NUM_RPORTS + 1;
    localparam int LW = DATA_WIDTH / WMASK_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    generate
        if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
            $error("sram_1rwnr_param_model: DEPTH out of range");
        end
        if (NUM_RPORTS < 1 || NUM_RPORTS > 4) begin : g_bad_rports
            $error("sram_1rwnr_param_model: NUM_RPORTS out of range");
        end
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("sram_1rwnr_param_model: READ_LATENCY out of range");
        end
        if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
            $error("sram_1rwnr_param_model: DATA_WIDTH not divisible by WMASK_WIDTH");
        end
    endgenerate

    typedef enum logic {ST_INIT, ST_READY} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic                  ready, wr_req, wr_ok, any_req, err_d, coll_d;
    logic [ADDR_WIDTH-1:0] rd_addr [NP];
    logic [NP-1:0]         rd_req, rd_inr;
    logic [DATA_WIDTH-1:0] rd_word [NP];
    logic [DATA_WIDTH-1:0] pipe_data [NP][READ_LATENCY];
    logic [NP-1:0]         pipe_vld [READ_LATENCY];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    assign ready   = (state_q == ST_READY);
    assign busy    = ~ready;
    assign wr_req  = ~csb0 & ~web0;
    assign wr_ok   = ready & wr_req & in_range(addr0);
    assign any_req = ~csb0 | ~(&csb1);

    // Index 0 is the read side of port 0; index i is read-only port i.
    always_comb begin
        rd_req     = '0;
        rd_addr[0] = addr0;
        rd_req[0]  = ready & ~csb0 & web0;
        for (int p = 1; p < NP; p++) begin
            rd_addr[p] = addr1[(p-1)*ADDR_WIDTH +: ADDR_WIDTH];
            rd_req[p]  = ready & ~csb1[p-1];
        end
    end

    always_comb begin
        err_d  = ~ready & any_req;
        coll_d = 1'b0;
        rd_inr = '0;
        if (ready && wr_req && !in_range(addr0)) err_d = 1'b1;
        for (int p = 0; p < NP; p++) begin
            rd_inr[p]  = in_range(rd_addr[p]);
            rd_word[p] = '0;
            if (rd_req[p] && !rd_inr[p]) err_d = 1'b1;
            if (rd_inr[p]) rd_word[p] = mem[rd_addr[p]];
            if (p > 0 && rd_req[p] && wr_ok && wmask0 != '0 && rd_addr[p] == addr0) begin
                coll_d = 1'b1;
                if (RDW_MODE == 1) begin
                    for (int k = 0; k < WMASK_WIDTH; k++) begin
                        if (wmask0[k]) rd_word[p][k*LW +: LW] = din0[k*LW +: LW];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (ptr_q == LAST_ADDR) state_d = ST_READY;
            default:  state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            access_err <= 1'b0;
            collision  <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (state_q == ST_INIT) ptr_q <= ptr_q + ADDR_WIDTH'(1);
            access_err <= err_d;
            collision  <= coll_d;
        end
    end

    // Storage is not reset; the init sequencer fills it after every reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_INIT) begin
                mem[ptr_q] <= INIT_VALUE;
            end else if (wr_ok) begin
                for (int k = 0; k < WMASK_WIDTH; k++) begin
                    if (wmask0[k]) mem[addr0][k*LW +: LW] <= din0[k*LW +: LW];
                end
            end
        end
    end

    // Data registers only load on a valid, so each output holds its last read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                pipe_vld[s] <= '0;
                for (int p = 0; p < NP; p++) pipe_data[p][s] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_req;
            for (int p = 0; p < NP; p++) begin
                if (rd_req[p]) pipe_data[p][0] <= rd_word[p];
            end
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                for (int p = 0; p < NP; p++) begin
                    if (pipe_vld[s-1][p]) pipe_data[p][s] <= pipe_data[p][s-1];
                end
            end
        end
    end

    assign dout0       = pipe_data[0][READ_LATENCY-1];
    assign dout0_valid = pipe_vld[READ_LATENCY-1][0];
    assign dout1_valid = pipe_vld[READ_LATENCY-1][NP-1:1];

    generate
        for (genvar g = 0; g < NUM_RPORTS; g++) begin : g_dout1
            assign dout1[g*DATA_WIDTH +: DATA_WIDTH] = pipe_data[g+1][READ_LATENCY-1];
        end
    endgenerate

endmodule

// File: tb/tb_sram_1rwnr_param_model.sv
// tb/tb_sram_1rwnr_param_model.sv - scoreboard bench for two sram_1rwnr_param_model configurations
module tb_sram_1rwnr_param_model;
    localparam logic [31:0] INIT_A = 32'h5A5A_0F0F;
    localparam logic [31:0] INIT_B = 32'h1357_9BDF;

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [8:0]  addr0;
    logic [31:0] din0;
    logic [1:0]  csb1;
    logic [17:0] addr1;

    logic        a_busy, a_dout0_valid, a_access_err, a_collision;
    logic [31:0] a_dout0;
    logic [63:0] a_dout1;
    logic [1:0]  a_dout1_valid;
    logic        b_busy, b_dout0_valid, b_access_err, b_collision;
    logic [31:0] b_dout0;
    logic [63:0] b_dout1;
    logic [1:0]  b_dout1_valid;

    int  checks = 0;
    int  errors = 0;
    int  cyc_cnt = 0;
    sb_t sbq [6][$];

    // Instance A: short non-power-of-two depth, 3-cycle reads, new-data RDW.
    sram_1rwnr_param_model #(
        .DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(300), .WMASK_WIDTH(4),
        .NUM_RPORTS(2), .READ_LATENCY(3), .RDW_MODE(1), .INIT_VALUE(INIT_A)
    ) u_a (
        .clk(clk), .reset(reset), .busy(a_busy),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(a_dout0), .dout0_valid(a_dout0_valid),
        .csb1(csb1), .addr1(addr1), .dout1(a_dout1), .dout1_valid(a_dout1_valid),
        .access_err(a_access_err), .collision(a_collision)
    );

    // Instance B: full depth, 1-cycle reads, old-data RDW.
    sram_1rwnr_param_model #(
        .DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(512), .WMASK_WIDTH(4),
        .NUM_RPORTS(2), .READ_LATENCY(1), .RDW_MODE(0), .INIT_VALUE(INIT_B)
    ) u_b (
        .clk(clk), .reset(reset), .busy(b_busy),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(b_dout0), .dout0_valid(b_dout0_valid),
        .csb1(csb1), .addr1(addr1), .dout1(b_dout1), .dout1_valid(b_dout1_valid),
        .access_err(b_access_err), .collision(b_collision)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mon(int idx, logic v, logic [31:0] d);
        sb_t e;
        if (v === 1'b1) begin
            if (sbq[idx].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL q%0d_unexpected_valid: got data %h with no pending read", idx, d);
            end else begin
                e = sbq[idx].pop_front();
                chk($sformatf("q%0d_data", idx), d, e.data);
                chk($sformatf("q%0d_cycle", idx), cyc_cnt, e.due);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_dout0_valid,    a_dout0);
        mon(1, a_dout1_valid[0], a_dout1[31:0]);
        mon(2, a_dout1_valid[1], a_dout1[63:32]);
        mon(3, b_dout0_valid,    b_dout0);
        mon(4, b_dout1_valid[0], b_dout1[31:0]);
        mon(5, b_dout1_valid[1], b_dout1[63:32]);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
        csb1 = 2'b11; addr1 = '0;
    endtask

    task automatic push(int idx, logic [31:0] d);
        sb_t e;
        e.data = d;
        e.due  = cyc_cnt + ((idx < 3) ? 3 : 1);
        sbq[idx].push_back(e);
    endtask

    task automatic exp_rd(int port, logic [31:0] ea, logic [31:0] eb);
        push(port, ea);
        push(port + 3, eb);
    endtask

    task automatic rd(int port, logic [8:0] a);
        case (port)
            0: begin csb0 = 1'b0; web0 = 1'b1; addr0 = a; end
            1: begin csb1[0] = 1'b0; addr1[8:0] = a; end
            default: begin csb1[1] = 1'b0; addr1[17:9] = a; end
        endcase
    endtask

    task automatic wr(logic [8:0] a, logic [31:0] d, logic [3:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    endtask

    task automatic flags(string nm, logic ea, logic eb, logic ca, logic cb);
        chk({nm, "_err_a"}, {31'b0, a_access_err}, {31'b0, ea});
        chk({nm, "_err_b"}, {31'b0, b_access_err}, {31'b0, eb});
        chk({nm, "_col_a"}, {31'b0, a_collision},  {31'b0, ca});
        chk({nm, "_col_b"}, {31'b0, b_collision},  {31'b0, cb});
    endtask

    task automatic wait_init(int poke_at, output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int i = 0; i < 1000; i++) begin
            if (a_busy) ca++;
            if (b_busy) cb++;
            if (!a_busy && !b_busy) break;
            if (i == poke_at) wr(9'h010, 32'hFFFF_FFFF, 4'hF);
            cyc();
            if (i == poke_at) begin
                flags("init_write", 1'b1, 1'b1, 1'b0, 1'b0);
                idle();
            end
        end
    endtask

    initial begin
        int ca, cb;
        idle();
        repeat (3) cyc();
        chk("rst_busy_a", {31'b0, a_busy}, 32'd1);
        chk("rst_busy_b", {31'b0, b_busy}, 32'd1);
        chk("rst_dout0_a", a_dout0, 32'd0);
        chk("rst_dout1_b", b_dout1[31:0] | b_dout1[63:32], 32'd0);
        chk("rst_valid_a", {29'b0, a_dout1_valid, a_dout0_valid}, 32'd0);
        flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);

        reset = 1'b0;
        wait_init(-1, ca, cb);
        chk("init_len_a", ca, 32'd300);
        chk("init_len_b", cb, 32'd512);

        rd(0, 9'h12B); exp_rd(0, INIT_A, INIT_B);
        rd(1, 9'h1FF); exp_rd(1, 32'h0, INIT_B);
        cyc(); flags("first_rd", 1'b1, 1'b0, 1'b0, 1'b0); idle();

        wr(9'h010, 32'hDEAD_BEEF, 4'hF); cyc(); flags("wr_full", 1'b0, 1'b0, 1'b0, 1'b0); idle();
        wr(9'h010, 32'h1122_3344, 4'h5); cyc(); idle();
        rd(0, 9'h010); exp_rd(0, 32'hDE22_BE44, 32'hDE22_BE44); cyc(); idle();
        repeat (5) cyc();
        chk("hold_dout0_a", a_dout0, 32'hDE22_BE44);
        chk("hold_dout0_b", b_dout0, 32'hDE22_BE44);

        for (int i = 0; i < 8; i++) begin
            wr(9'(i), 32'hA500_0000 | 32'(i), 4'hF); cyc();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            idle();
            rd(1, 9'(i));     exp_rd(1, 32'hA500_0000 | 32'(i), 32'hA500_0000 | 32'(i));
            rd(2, 9'(7 - i)); exp_rd(2, 32'hA500_0000 | 32'(7 - i), 32'hA500_0000 | 32'(7 - i));
            cyc();
        end
        idle();

        wr(9'h020, 32'h1234_5678, 4'hF); cyc(); idle();
        wr(9'h020, 32'hAAAA_5555, 4'hF);
        rd(1, 9'h020); exp_rd(1, 32'hAAAA_5555, 32'h1234_5678);
        rd(2, 9'h021); exp_rd(2, INIT_A, INIT_B);
        cyc(); flags("rdw_full", 1'b0, 1'b0, 1'b1, 1'b1); idle();
        wr(9'h020, 32'h0000_FFFF, 4'h3);
        rd(1, 9'h020); exp_rd(1, 32'hAAAA_FFFF, 32'hAAAA_5555);
        cyc(); flags("rdw_part", 1'b0, 1'b0, 1'b1, 1'b1); idle();
        rd(1, 9'h010); rd(2, 9'h010);
        exp_rd(1, 32'hDE22_BE44, 32'hDE22_BE44); exp_rd(2, 32'hDE22_BE44, 32'hDE22_BE44);
        cyc(); flags("dual_rd", 1'b0, 1'b0, 1'b0, 1'b0); idle();
        wr(9'h020, 32'h0, 4'h0);
        rd(1, 9'h020); exp_rd(1, 32'hAAAA_FFFF, 32'hAAAA_FFFF);
        cyc(); flags("mask0", 1'b0, 1'b0, 1'b0, 1'b0); idle();

        wr(9'h150, 32'hFFFF_FFFF, 4'hF); cyc(); flags("oor_wr", 1'b1, 1'b0, 1'b0, 1'b0); idle();
        rd(0, 9'h150); exp_rd(0, 32'h0, 32'hFFFF_FFFF);
        rd(1, 9'h050); exp_rd(1, INIT_A, INIT_B);
        rd(2, 9'h024); exp_rd(2, INIT_A, INIT_B);
        cyc(); flags("oor_rd", 1'b1, 1'b0, 1'b0, 1'b0); idle();
        rd(1, 9'h12B); exp_rd(1, INIT_A, INIT_B); cyc(); idle();
        repeat (4) cyc();

        // Only instance B can deliver these before reset lands; A's copies must vanish.
        rd(0, 9'h010); push(3, 32'hDE22_BE44); cyc(); idle();
        rd(1, 9'h010); push(4, 32'hDE22_BE44); cyc(); idle();
        reset = 1'b1;
        repeat (4) cyc();
        chk("flush_dout0_a", a_dout0, 32'd0);
        chk("flush_dout0_b", b_dout0, 32'd0);
        chk("flush_busy_b", {31'b0, b_busy}, 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 20) begin rd(0, 9'h005); rd(1, 9'h006); end
            cyc();
            if (i == 20) begin flags("init_rd", 1'b1, 1'b1, 1'b0, 1'b0); idle(); end
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        wait_init(50, ca, cb);
        chk("reinit_len_a", ca, 32'd300);
        chk("reinit_len_b", cb, 32'd512);
        rd(0, 9'h010); exp_rd(0, INIT_A, INIT_B);
        rd(1, 9'h020); exp_rd(1, INIT_A, INIT_B);
        cyc(); idle();
        repeat (10) cyc();

        for (int i = 0; i < 6; i++) chk($sformatf("q%0d_drain", i), sbq[i].size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
